// File: rtl/water_box_controller_pkg.sv
// Shared types and helpers for the water-box tank controller.
// State encodings, count width, level codes and saturating count arithmetic.
package water_box_controller_pkg;

   localparam int COUNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FILL  = 2'b01,
      ST_DRAIN = 2'b10,
      ST_FAULT = 2'b11
   } wb_state_e;

   // Codes produced by the downstream level encoder.
   typedef enum logic [1:0] {
      LVL_C = 2'b00,
      LVL_L = 2'b01,
      LVL_M = 2'b10,
      LVL_H = 2'b11
   } wb_level_e;

   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
   localparam logic [COUNT_W-1:0] COUNT_ONE = 1;

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
      return (c == COUNT_MAX) ? c : c + COUNT_ONE;
   endfunction

   function automatic logic [COUNT_W-1:0] sat_dec(input logic [COUNT_W-1:0] c);
      return (c == '0) ? c : c - COUNT_ONE;
   endfunction

endpackage

// File: rtl/water_box_watchdog.sv
// Dry-pump watchdog: counts enabled cycles since the last clear and flags
// the cycle on which TIMEOUT_CYC consecutive quiet cycles have elapsed.
module water_box_watchdog #(
   parameter int TIMEOUT_CYC = 1000,
   parameter int TIMEOUT_W   = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_timeout
);

   localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
   localparam logic [TIMEOUT_W-1:0] ONE  = 1;

   logic [TIMEOUT_W-1:0] r_cnt;

   // Fires during the final quiet cycle so the FSM leaves exactly TIMEOUT_CYC
   // cycles after entering FILL (or after the last pulse).
   assign o_timeout = i_en && !i_clr && (r_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              r_cnt <= '0;
      else if (!i_en || i_clr) r_cnt <= '0;
      else if (r_cnt != LAST)  r_cnt <= r_cnt + ONE;
   end

endmodule

// File: rtl/water_box_controller.sv
// Water-box tank sequencer: arbitrates pump fill against outlet drain, owns the
// tank count and direction flag, with refill hysteresis, dry-pump watchdog and overflow lockout.
module water_box_controller
   import water_box_controller_pkg::*;
#(
   parameter logic [COUNT_W-1:0] FILL_TARGET = 3'd7,
   parameter logic [COUNT_W-1:0] LOW_THRESH  = 3'd1,
   parameter int                 TIMEOUT_CYC = 1000,
   parameter int                 TIMEOUT_W   = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               step_pulse,
   input  logic               consume,
   input  logic               manual_fill,
   input  logic               sensor_overflow,
   input  logic               fault_clr,
   output logic [COUNT_W-1:0] count_0_7,
   output logic               direction,
   output logic               pump_on,
   output logic               valve_out,
   output logic               grant,
   output logic               alarm,
   output logic [1:0]         state
);

   wb_state_e          r_state, w_state_nxt;
   logic [COUNT_W-1:0] r_count, w_count_nxt;
   logic [COUNT_W-1:0] w_inc, w_dec;
   logic               r_dir, w_dir_nxt;
   logic               w_timeout;

   assign w_inc = sat_inc(r_count);
   assign w_dec = sat_dec(r_count);

   water_box_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TIMEOUT_W   (TIMEOUT_W)
   ) u_wdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (r_state == ST_FILL),
      .i_clr     (step_pulse),
      .o_timeout (w_timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_dir   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_dir   <= w_dir_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_dir_nxt   = r_dir;
      // Overflow pre-empts everything, including a coincident step.
      if (sensor_overflow) begin
         w_state_nxt = ST_FAULT;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_count <= LOW_THRESH)                          w_state_nxt = ST_FILL;
               else if (manual_fill && (r_count < FILL_TARGET))    w_state_nxt = ST_FILL;
               else if (consume)                                   w_state_nxt = ST_DRAIN;
            end
            ST_FILL: begin
               if (r_count >= FILL_TARGET) begin
                  w_state_nxt = ST_IDLE;
               end else if (step_pulse) begin
                  w_count_nxt = w_inc;
                  if (w_inc >= FILL_TARGET) w_state_nxt = ST_IDLE;
               end else if (w_timeout) begin
                  w_state_nxt = ST_FAULT;
               end
            end
            ST_DRAIN: begin
               if (!consume) begin
                  w_state_nxt = ST_IDLE;
               end else if (step_pulse) begin
                  w_count_nxt = w_dec;
                  if (w_dec <= LOW_THRESH) w_state_nxt = ST_FILL;
               end
            end
            ST_FAULT: begin
               if (fault_clr) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
      // Direction only changes on entry to a motion state.
      if ((w_state_nxt == ST_FILL) && (r_state != ST_FILL))   w_dir_nxt = 1'b1;
      if ((w_state_nxt == ST_DRAIN) && (r_state != ST_DRAIN)) w_dir_nxt = 1'b0;
   end

   assign count_0_7 = r_count;
   assign direction = r_dir;
   assign pump_on   = (r_state == ST_FILL);
   assign valve_out = (r_state == ST_DRAIN);
   assign grant     = (r_state == ST_DRAIN);
   assign alarm     = (r_state == ST_FAULT);
   assign state     = r_state;

endmodule

// File: tb/tb_water_box_controller.sv
// Bench for water_box_controller: a cycle model pushes expected outputs into a
// scoreboard queue as stimulus is driven; entries are popped and compared after each edge.
module tb_water_box_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       step_pulse = 1'b0, consume = 1'b0, manual_fill = 1'b0;
   logic       sensor_overflow = 1'b0, fault_clr = 1'b0;
   logic [2:0] count_0_7;
   logic       direction, pump_on, valve_out, grant, alarm;
   logic [1:0] state;

   int n_tot = 0;
   int n_bad = 0;

   logic [9:0] sb_q[$];

   int m_st, m_cnt, m_dir, m_wd;

   water_box_controller dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .step_pulse      (step_pulse),
      .consume         (consume),
      .manual_fill     (manual_fill),
      .sensor_overflow (sensor_overflow),
      .fault_clr       (fault_clr),
      .count_0_7       (count_0_7),
      .direction       (direction),
      .pump_on         (pump_on),
      .valve_out       (valve_out),
      .grant           (grant),
      .alarm           (alarm),
      .state           (state)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] obs();
      return {state, count_0_7, direction, pump_on, valve_out, grant, alarm};
   endfunction

   function automatic logic [9:0] model_exp();
      logic [1:0] s;
      logic [2:0] c;
      s = 2'(m_st);
      c = 3'(m_cnt);
      return {s, c, (m_dir != 0), (m_st == 1), (m_st == 2), (m_st == 2), (m_st == 3)};
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_st = 0; m_cnt = 0; m_dir = 0; m_wd = 0;
   endtask

   task automatic m_step(input logic s, input logic c, input logic m, input logic o, input logic f);
      int nst, ncnt, ndir, nwd;
      nst = m_st; ncnt = m_cnt; ndir = m_dir;
      nwd = (m_st == 1 && !s) ? m_wd + 1 : 0;
      if (o) nst = 3;
      else if (m_st == 0) begin
         if (m_cnt <= 1 || (m && m_cnt < 7)) nst = 1;
         else if (c) nst = 2;
      end else if (m_st == 1) begin
         if (s) begin
            ncnt = (m_cnt == 7) ? 7 : m_cnt + 1;
            if (ncnt == 7) nst = 0;
         end else if (m_wd == 999) nst = 3;
      end else if (m_st == 2) begin
         if (!c) nst = 0;
         else if (s) begin
            ncnt = (m_cnt == 0) ? 0 : m_cnt - 1;
            if (ncnt <= 1) nst = 1;
         end
      end else begin
         if (f) nst = 0;
      end
      if (nst == 1 && m_st != 1) ndir = 1;
      if (nst == 2 && m_st != 2) ndir = 0;
      m_st = nst; m_cnt = ncnt; m_dir = ndir; m_wd = nwd;
   endtask

   // One clock: drive at negedge, predict, then compare just after the rising edge.
   task automatic cyc(input logic s, input logic c, input logic m = 1'b0,
                      input logic o = 1'b0, input logic f = 1'b0);
      @(negedge clk);
      step_pulse = s; consume = c; manual_fill = m; sensor_overflow = o; fault_clr = f;
      if (!rst_n) m_reset();
      else        m_step(s, c, m, o, f);
      sb_q.push_back(model_exp());
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) chk("sb_empty", 16'd1, 16'd0);
      else                  chk("cyc", obs(), sb_q.pop_front());
   endtask

   initial begin
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", obs(), 10'd0);

      // T1: empty tank forces FILL, seven steps fill it.
      rst_n = 1'b1;
      cyc(0, 0);
      chk("t1_fill", state, 2'b01);
      chk("t1_dir", direction, 1'b1);
      repeat (7) cyc(1, 0);
      chk("t1_cnt", count_0_7, 3'd7);
      chk("t1_idle", {state, pump_on}, 3'b000);
      cyc(1, 0);
      chk("t1_idle_step_ign", count_0_7, 3'd7);

      // T2: drain four, then release consume.
      cyc(0, 1);
      repeat (4) cyc(1, 1);
      chk("t2_cnt", count_0_7, 3'd3);
      chk("t2_grant", {valve_out, grant, direction}, 3'b110);
      cyc(0, 0);
      chk("t2_idle", {state, count_0_7}, {2'b00, 3'd3});

      // T3: drain into low threshold flips straight to FILL.
      cyc(0, 1);
      cyc(1, 1);
      cyc(1, 1);
      chk("t3_fill", {state, count_0_7, grant, pump_on}, {2'b01, 3'd1, 1'b0, 1'b1});
      repeat (2) cyc(0, 1);
      chk("t3_fill_wins", state, 2'b01);

      // T4: watchdog fires on the 1000th quiet FILL cycle.
      repeat (997) cyc(0, 0);
      chk("t4_pre", state, 2'b01);
      cyc(0, 0);
      chk("t4_fault", {state, alarm, pump_on}, {2'b11, 1'b1, 1'b0});
      cyc(0, 0, 0, 0, 1);
      chk("t4_clr", state, 2'b00);
      cyc(0, 0);
      chk("t4_refill", state, 2'b01);
      repeat (6) cyc(1, 0);
      cyc(0, 1);
      repeat (2) cyc(1, 1);
      chk("t4_cnt5", count_0_7, 3'd5);

      // T5: overflow beats a coincident step; clear is blocked while overflow holds.
      cyc(1, 1, 0, 1, 0);
      chk("t5_fault", {state, count_0_7}, {2'b11, 3'd5});
      cyc(0, 1, 0, 1, 1);
      chk("t5_clr_blocked", state, 2'b11);
      cyc(0, 0);
      cyc(0, 0, 0, 0, 1);
      chk("t5_clr", {state, count_0_7}, {2'b00, 3'd5});

      // T6: asynchronous reset in the middle of FILL at count 4.
      cyc(0, 1);
      cyc(1, 1);
      cyc(0, 0);
      cyc(0, 0, 1);
      chk("t6_fill4", {state, count_0_7}, {2'b01, 3'd4});
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async", obs(), 10'd0);
      repeat (2) cyc(0, 0);
      rst_n = 1'b1;
      cyc(0, 0);
      chk("t6_release", {state, pump_on}, 3'b011);

      // Random traffic against the model.
      repeat (500)
         cyc($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0,
             $urandom_range(0, 5) == 0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
